// File: rtl/cfg_arbiter.sv
// N-way grant arbiter with run-time fixed-priority / round-robin selection and grant lock.
// The registered decision and its index/valid flag shift together through DELAY more stages.
module cfg_arbiter #(
  parameter int N     = 4,
  parameter int DELAY = 2,
  parameter int IDW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic           hold,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  logic [IDW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]            last_id_q, last_id_d;
  logic                      last_vld_q, last_vld_d;
  logic [DELAY:0][N-1:0]     gnt_pipe_q, gnt_pipe_d;
  logic [DELAY:0][IDW-1:0]   id_pipe_q, id_pipe_d;
  logic [DELAY:0]            vld_pipe_q, vld_pipe_d;

  logic [IDW-1:0] lo_id, rr_id, win_id;
  logic           lo_found, rr_found, use_hold, any_req;

  always_comb begin
    lo_id    = '0;
    lo_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!lo_found && req[i]) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
      end
    end
  end

  // Round-robin scan: indices at or above the pointer first, then the wrapped part.
  always_comb begin
    rr_id    = '0;
    rr_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!rr_found && req[i] && (i >= int'(rr_ptr_q))) begin
        rr_found = 1'b1;
        rr_id    = IDW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!rr_found && req[i] && (i < int'(rr_ptr_q))) begin
        rr_found = 1'b1;
        rr_id    = IDW'(i);
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    last_id_d  = last_id_q;
    last_vld_d = last_vld_q;
    any_req    = |req;
    use_hold   = hold && last_vld_q && req[last_id_q];
    win_id     = use_hold ? last_id_q : (mode ? rr_id : lo_id);
    if (any_req) begin
      last_id_d  = win_id;
      last_vld_d = 1'b1;
      if (mode && !use_hold) begin
        rr_ptr_d = (rr_id == IDW'(N - 1)) ? '0 : rr_id + IDW'(1);
      end
    end
    gnt_pipe_d = {gnt_pipe_q[DELAY-1:0], (any_req ? (N'(1) << win_id) : N'(0))};
    id_pipe_d  = {id_pipe_q[DELAY-1:0], (any_req ? win_id : IDW'(0))};
    vld_pipe_d = {vld_pipe_q[DELAY-1:0], any_req};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      last_id_q  <= '0;
      last_vld_q <= 1'b0;
      gnt_pipe_q <= '0;
      id_pipe_q  <= '0;
      vld_pipe_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      last_id_q  <= last_id_d;
      last_vld_q <= last_vld_d;
      gnt_pipe_q <= gnt_pipe_d;
      id_pipe_q  <= id_pipe_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign gnt       = gnt_pipe_q[DELAY];
  assign gnt_id    = id_pipe_q[DELAY];
  assign gnt_valid = vld_pipe_q[DELAY];

endmodule

// File: tb/tb_cfg_arbiter.sv
// Bench for cfg_arbiter (N=4, DELAY=2): directed vector table, hand-written reset
// corner sequence, and a random run against a behavioural arbitration model.
module tb_cfg_arbiter;

  localparam int N     = 4;
  localparam int DELAY = 2;
  localparam int IDW   = 2;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b1;
  logic           mode  = 1'b0;
  logic           hold  = 1'b0;
  logic [N-1:0]   req   = '0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;

  int checks = 0;
  int errors = 0;

  cfg_arbiter #(.N(N), .DELAY(DELAY), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .hold(hold), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst_before;
    logic [N-1:0] req;
    logic         mode;
    logic         hold;
    logic [N-1:0] exp_gnt;
  } vec_t;

  vec_t vecs[$];

  // Behavioural reference: expected grant pipeline plus arbitration state.
  logic [N-1:0] m_pipe [0:DELAY];
  int           m_ptr;
  int           m_last;
  bit           m_last_vld;

  function automatic logic [IDW-1:0] idxOf(input logic [N-1:0] g);
    logic [IDW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = IDW'(i);
    return r;
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [N-1:0] exp_gnt);
    compare({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    compare({tag, ".gnt_id"}, 32'(gnt_id), 32'(idxOf(exp_gnt)));
    compare({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(|exp_gnt));
  endtask

  task automatic modelReset();
    for (int s = 0; s <= DELAY; s++) m_pipe[s] = '0;
    m_ptr      = 0;
    m_last     = 0;
    m_last_vld = 1'b0;
  endtask

  task automatic modelStep(input logic [N-1:0] r, input logic m, input logic h);
    logic [N-1:0] d;
    int           w;
    bit           f;
    d = '0;
    w = 0;
    f = 1'b0;
    if (r != '0) begin
      if (h && m_last_vld && r[m_last]) begin
        w = m_last;
        f = 1'b1;
      end else if (!m) begin
        for (int i = 0; i < N && !f; i++) if (r[i]) begin w = i; f = 1'b1; end
      end else begin
        for (int k = 0; k < N && !f; k++) begin
          if (r[(m_ptr + k) % N]) begin
            w     = (m_ptr + k) % N;
            f     = 1'b1;
            m_ptr = (w + 1) % N;
          end
        end
      end
      d[w]       = 1'b1;
      m_last     = w;
      m_last_vld = 1'b1;
    end
    for (int s = DELAY; s > 0; s--) m_pipe[s] = m_pipe[s-1];
    m_pipe[0] = d;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    req   = '0;
    mode  = 1'b0;
    hold  = 1'b0;
    modelReset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic m, input logic h);
    @(negedge clk);
    req  = r;
    mode = m;
    hold = h;
    modelStep(r, m, h);
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic rb, input logic [N-1:0] r, input logic m,
                        input logic h, input logic [N-1:0] e);
    vec_t v;
    v.rst_before = rb;
    v.req        = r;
    v.mode       = m;
    v.hold       = h;
    v.exp_gnt    = e;
    vecs.push_back(v);
  endtask

  initial begin
    // Single fixed-priority request, 3-edge latency, one-cycle pulse
    addVec(1, 4'b0110, 0, 0, 4'b0000);
    addVec(0, 4'b0000, 0, 0, 4'b0000);
    addVec(0, 4'b0000, 0, 0, 4'b0010);
    addVec(0, 4'b0000, 0, 0, 4'b0000);
    // Round-robin over all requesters with pointer wrap
    addVec(1, 4'b1111, 1, 0, 4'b0000);
    addVec(0, 4'b1111, 1, 0, 4'b0000);
    addVec(0, 4'b1111, 1, 0, 4'b0001);
    addVec(0, 4'b1111, 1, 0, 4'b0010);
    addVec(0, 4'b1111, 1, 0, 4'b0100);
    addVec(0, 4'b1111, 1, 0, 4'b1000);
    addVec(0, 4'b1111, 1, 0, 4'b0001);
    addVec(0, 4'b1111, 1, 0, 4'b0010);
    addVec(0, 4'b0000, 1, 0, 4'b0100);
    addVec(0, 4'b0000, 1, 0, 4'b1000);
    // Pointer wrap from 3 and pointer retained across idle cycles
    addVec(1, 4'b1000, 1, 0, 4'b0000);
    addVec(0, 4'b0101, 1, 0, 4'b0000);
    addVec(0, 4'b0000, 1, 0, 4'b1000);
    addVec(0, 4'b0000, 1, 0, 4'b0001);
    addVec(0, 4'b0101, 1, 0, 4'b0000);
    addVec(0, 4'b0000, 1, 0, 4'b0000);
    addVec(0, 4'b0000, 1, 0, 4'b0100);
    // Grant lock, then release when the locked requester drops
    addVec(1, 4'b0011, 1, 1, 4'b0000);
    addVec(0, 4'b0011, 1, 1, 4'b0000);
    addVec(0, 4'b0011, 1, 1, 4'b0001);
    addVec(0, 4'b0011, 1, 1, 4'b0001);
    addVec(0, 4'b0010, 1, 1, 4'b0001);
    addVec(0, 4'b0000, 1, 1, 4'b0001);
    addVec(0, 4'b0000, 1, 1, 4'b0010);
    // Mode switching keeps the round-robin pointer
    addVec(1, 4'b0011, 1, 0, 4'b0000);
    addVec(0, 4'b0011, 0, 0, 4'b0000);
    addVec(0, 4'b0011, 1, 0, 4'b0001);
    addVec(0, 4'b0001, 1, 0, 4'b0001);
    addVec(0, 4'b0000, 1, 0, 4'b0010);
    addVec(0, 4'b0000, 1, 0, 4'b0001);
    // Lock overrides fixed priority
    addVec(1, 4'b0100, 0, 0, 4'b0000);
    addVec(0, 4'b0110, 0, 1, 4'b0000);
    addVec(0, 4'b0110, 0, 0, 4'b0100);
    addVec(0, 4'b0000, 0, 0, 4'b0100);
    addVec(0, 4'b0000, 0, 0, 4'b0010);

    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset", 4'b0000);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) resetDut();
      applyStimulus(vecs[i].req, vecs[i].mode, vecs[i].hold);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_gnt);
    end

    // Asynchronous reset in the middle of a round-robin stream
    resetDut();
    repeat (4) applyStimulus(4'b1111, 1'b1, 1'b0);
    checkOutput("pre_rst", 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", 4'b0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst1", 4'b0000);
    @(posedge clk); #1;
    checkOutput("post_rst2", 4'b0000);
    @(posedge clk); #1;
    checkOutput("post_rst3", 4'b0001);
    @(posedge clk); #1;
    checkOutput("post_rst4", 4'b0010);

    // Random traffic against the reference model
    resetDut();
    for (int c = 0; c < 10000; c++) begin
      applyStimulus(N'($urandom_range(0, (1 << N) - 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      checkOutput($sformatf("rand%0d", c), m_pipe[DELAY]);
      compare($sformatf("rand%0d.onehot", c), 32'($onehot0(gnt)), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
